// File: rtl/state_digest_unit.sv
// state_digest_unit: snapshots engine state on HALT and folds it into a
// 256-bit xorshift-mixed digest, one 32-bit mix step per cycle.
module state_digest_unit #(
    parameter int SH1 = 13,
    parameter int SH2 = 17,
    parameter int SH3 = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  pc,
    input  logic [31:0]  next_id,
    input  logic [31:0]  num_modules,
    input  logic [31:0]  step_count,
    input  logic [63:0]  mu_discovery,
    input  logic [63:0]  mu_execution,
    input  logic [63:0]  mask0,
    input  logic [63:0]  mask1,
    input  logic [31:0]  mem0,
    input  logic [31:0]  mem1,
    output logic         busy,
    output logic [255:0] digest,
    output logic [63:0]  mu_total,
    output logic         digest_valid,
    input  logic         digest_ready
);

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0][31:0]  lane_q, lane_d;
    logic [63:0]       mu_q, mu_d;
    logic [2:0]        idx_q, idx_d;
    logic [1:0]        step_q, step_d;
    logic [63:0]       mu_sum;
    logic              capture;
    logic              last_step;
    logic              unused_hi;

    // Only the low halves of the partition masks feed the digest.
    assign unused_hi = ^{mask0[63:32], mask1[63:32]};

    function automatic logic [31:0] mix_step(input logic [31:0] x,
                                             input logic [1:0]  s);
        logic [31:0] r;
        case (s)
            2'd0:    r = x ^ (x << SH1);
            2'd1:    r = x ^ (x >> SH2);
            default: r = x ^ (x << SH3);
        endcase
        return r;
    endfunction

    assign mu_sum    = mu_discovery + mu_execution;
    assign capture   = (state_q == IDLE) && start;
    assign last_step = (idx_q == 3'd7) && (step_q == 2'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start outside IDLE is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)        state_d = MIX;
            MIX:     if (last_step)    state_d = DONE;
            DONE:    if (digest_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy         = 1'b0;
        digest_valid = 1'b0;
        case (state_q)
            MIX:     busy = 1'b1;
            DONE: begin
                busy         = 1'b1;
                digest_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: capture the snapshot, then mix one lane step.
    always_comb begin
        lane_d = lane_q;
        mu_d   = mu_q;
        idx_d  = idx_q;
        step_d = step_q;
        if (capture) begin
            lane_d[0] = pc ^ next_id;
            lane_d[1] = num_modules ^ step_count;
            lane_d[2] = mu_discovery[31:0] ^ mu_execution[31:0];
            lane_d[3] = mu_sum[31:0];
            lane_d[4] = mask0[31:0];
            lane_d[5] = mask1[31:0];
            lane_d[6] = mem0;
            lane_d[7] = mem1;
            mu_d      = mu_sum;
            idx_d     = 3'd0;
            step_d    = 2'd0;
        end else if (state_q == MIX) begin
            lane_d[idx_q] = mix_step(lane_q[idx_q], step_q);
            if (step_q == 2'd2) begin
                step_d = 2'd0;
                idx_d  = idx_q + 3'd1;
            end else begin
                step_d = step_q + 2'd1;
            end
        end
    end

    // Datapath registers; reset discards any partial digest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            mu_q   <= '0;
            idx_q  <= '0;
            step_q <= '0;
        end else begin
            lane_q <= lane_d;
            mu_q   <= mu_d;
            idx_q  <= idx_d;
            step_q <= step_d;
        end
    end

    assign digest   = lane_q;
    assign mu_total = mu_q;

endmodule

// File: tb/tb_state_digest_unit.sv
// tb_state_digest_unit: random and directed checks of state_digest_unit
// against a lane-by-lane xorshift reference model.
module tb_state_digest_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  pc, next_id, num_modules, step_count;
    logic [63:0]  mu_discovery, mu_execution, mask0, mask1;
    logic [31:0]  mem0, mem1;
    logic         busy;
    logic [255:0] digest;
    logic [63:0]  mu_total;
    logic         digest_valid;
    logic         digest_ready;

    int n_chk  = 0;
    int n_pass = 0;

    state_digest_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pc           (pc),
        .next_id      (next_id),
        .num_modules  (num_modules),
        .step_count   (step_count),
        .mu_discovery (mu_discovery),
        .mu_execution (mu_execution),
        .mask0        (mask0),
        .mask1        (mask1),
        .mem0         (mem0),
        .mem1         (mem1),
        .busy         (busy),
        .digest       (digest),
        .mu_total     (mu_total),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [63:0] ref_mu();
        return mu_discovery + mu_execution;
    endfunction

    function automatic logic [255:0] ref_digest();
        logic [31:0]  l [8];
        logic [63:0]  s;
        logic [255:0] d;
        s    = ref_mu();
        l[0] = pc ^ next_id;
        l[1] = num_modules ^ step_count;
        l[2] = mu_discovery[31:0] ^ mu_execution[31:0];
        l[3] = s[31:0];
        l[4] = mask0[31:0];
        l[5] = mask1[31:0];
        l[6] = mem0;
        l[7] = mem1;
        d = '0;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = xs(l[i]);
        return d;
    endfunction

    task automatic zero_inputs();
        pc = 0; next_id = 0; num_modules = 0; step_count = 0;
        mu_discovery = 0; mu_execution = 0; mask0 = 0; mask1 = 0;
        mem0 = 0; mem1 = 0;
    endtask

    task automatic rand_inputs();
        pc           = $urandom; next_id    = $urandom;
        num_modules  = $urandom; step_count = $urandom;
        mu_discovery = {$urandom, $urandom};
        mu_execution = {$urandom, $urandom};
        mask0        = {$urandom, $urandom};
        mask1        = {$urandom, $urandom};
        mem0         = $urandom; mem1 = $urandom;
    endtask

    // Pulse start at a negedge; return after the T0 edge's negedge.
    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_t0"}, 256'(busy), 256'(1));
        chk({tag, "_mu_t0"}, 256'(mu_total), 256'(ref_mu()));
    endtask

    task automatic wait_valid(input string tag);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (digest_valid) break;
        end
        chk({tag, "_lat"}, 256'(cnt), 256'(24));
    endtask

    task automatic handshake(input string tag);
        digest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        chk({tag, "_hs_valid"}, 256'(digest_valid), 256'(0));
        chk({tag, "_hs_busy"}, 256'(busy), 256'(0));
    endtask

    task automatic full_run(input string tag);
        logic [255:0] ed;
        logic [63:0]  em;
        ed = ref_digest();
        em = ref_mu();
        do_start(tag);
        wait_valid(tag);
        chk({tag, "_digest"}, digest, ed);
        chk({tag, "_mu"}, 256'(mu_total), 256'(em));
        handshake(tag);
    endtask

    initial begin
        logic [255:0] hold_d;
        logic [63:0]  hold_m;
        logic [255:0] lane_map;

        rst_n = 1'b0; start = 1'b0; digest_ready = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_valid", 256'(digest_valid), 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_mu", 256'(mu_total), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        zero_inputs();
        full_run("zero");

        zero_inputs();
        mu_discovery = 64'd1;
        full_run("single_mu");
        chk("single_mu_l2", 256'(digest[95:64]), 256'(32'h00042021));
        chk("single_mu_l3", 256'(digest[127:96]), 256'(32'h00042021));

        zero_inputs();
        mask0 = 64'h1;
        mem1  = 32'h1;
        lane_map = '0;
        lane_map[159:128] = 32'h00042021;
        lane_map[255:224] = 32'h00042021;
        do_start("map");
        wait_valid("map");
        chk("map_digest", digest, lane_map);
        handshake("map");

        zero_inputs();
        pc = 32'd5; next_id = 32'd5; mem0 = 32'hdead_beef;
        full_run("pc_eq");
        chk("pc_eq_l0", 256'(digest[31:0]), 256'(0));

        zero_inputs();
        mu_discovery = 64'hFFFF_FFFF_FFFF_FFFF;
        mu_execution = 64'd2;
        full_run("wrap");
        chk("wrap_mu1", 256'(mu_total), 256'(1));
        chk("wrap_l3", 256'(digest[127:96]), 256'(32'h00042021));

        for (int r = 0; r < 8; r++) begin
            rand_inputs();
            full_run($sformatf("rnd%0d", r));
        end

        // Back-pressure with start pulses that must be ignored.
        rand_inputs();
        hold_d = ref_digest();
        hold_m = ref_mu();
        do_start("bp");
        wait_valid("bp");
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            start = k[0];
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_d%0d", k), digest, hold_d);
            chk($sformatf("bp_m%0d", k), 256'(mu_total), 256'(hold_m));
            chk($sformatf("bp_v%0d", k), 256'(digest_valid), 256'(1));
        end
        start = 1'b0;
        handshake("bp");
        chk("bp_keep_d", digest, hold_d);
        chk("bp_keep_m", 256'(mu_total), 256'(hold_m));

        // Start on the handshake edge is dropped.
        rand_inputs();
        do_start("hsst");
        wait_valid("hsst");
        rand_inputs();
        start = 1'b1;
        handshake("hsst");
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hsst_idle", 256'(busy), 256'(0));

        // Ready asserted during MIX has no effect.
        rand_inputs();
        hold_d = ref_digest();
        do_start("rdy");
        digest_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        chk("rdy_busy", 256'(busy), 256'(1));
        for (int k = 0; k < 40 && !digest_valid; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rdy_valid", 256'(digest_valid), 256'(1));
        chk("rdy_digest", digest, hold_d);
        handshake("rdy");

        // Reset in the middle of MIX.
        rand_inputs();
        do_start("rstmix");
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmix_busy", 256'(busy), 256'(0));
        chk("rstmix_digest", digest, 256'(0));
        chk("rstmix_mu", 256'(mu_total), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        rand_inputs();
        full_run("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/state_digest_unit.md
# state_digest_unit

Synthesizable finaliser that sits directly downstream of the fuzz execution engine. On HALT it captures a snapshot of the machine state and computes `mu_total`. It then folds the snapshot into the 256-bit xorshift-mixed `final_hash` compared against the Python VM. The design does one mixing step per cycle to keep the critical path to a single 32-bit shift/XOR, and returns the result over a valid/ready handshake.

## Interface
Parameters:
- `SH1`, default 13: first left-shift amount of the xorshift mix.
- `SH2`, default 17: right-shift amount.
- `SH3`, default 5: second left-shift amount.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: capture request, single-cycle pulse from the engine on HALT.
- `pc`, `next_id`, `num_modules`, `step_count`, in, 32 each: engine state.
- `mu_discovery`, `mu_execution`, in, 64 each: μ-cost accumulators.
- `mask0`, `mask1`, in, 64 each: partition masks of modules 0 and 1.
- `mem0`, `mem1`, in, 32 each: `data_memory[0]` and `data_memory[1]`.
- `busy`, out, 1: high while in MIX or DONE.
- `digest`, out, 256: final hash, with lane i at bits `[i*32 +: 32]`.
- `mu_total`, out, 64: `mu_discovery + mu_execution`.
- `digest_valid`, out, 1: result available.
- `digest_ready`, in, 1: consumer accepts the result.

## Operation
- **FSM states:** IDLE, MIX, DONE. Reset state is IDLE.
- **Outputs under reset:** `digest`, `mu_total`, `digest_valid` and `busy` are all 0. A lane index counter (3 bit) and a step counter (2 bit) are also cleared to 0.
- **Capture (IDLE with `start`=1).** All lanes and `mu_total` are loaded on the same edge, and the FSM moves to MIX.
  - lane0 = `pc ^ next_id`
  - lane1 = `num_modules ^ step_count`
  - lane2 = `mu_discovery[31:0] ^ mu_execution[31:0]`
  - lane3 = low 32 bits of (`mu_discovery + mu_execution`)
  - lane4 = `mask0[31:0]`
  - lane5 = `mask1[31:0]`
  - lane6 = `mem0`
  - lane7 = `mem1`
  - `mu_total` = 64-bit sum, modulo 2^64.
- **MIX.** Each cycle applies one step to lane[idx]:
  - step 0: `x ^= x << SH1`
  - step 1: `x ^= x >> SH2`
  - step 2: `x ^= x << SH3`
  - Shifts are logical and the result is truncated to 32 bits.
  - After step 2 the step counter wraps to 0 and idx increments.
  - After lane 7 step 2 the FSM moves to DONE.
- **DONE.** `digest_valid`=1 and `digest` is stable. An edge with `digest_ready`=1 moves the FSM to IDLE and clears `digest_valid`. `digest` and `mu_total` keep their values until the next capture.
- **Ignored inputs.**
  - `start` in MIX or DONE is ignored; no queueing.
  - `digest_ready` outside DONE is ignored.
- **Start on the handshake edge.** If `start` arrives on the same cycle as the DONE handshake, it is ignored. The FSM is not in IDLE on that edge.
- **Reset mid-operation.** Reset in any state returns to IDLE with all outputs 0. The partial digest is discarded.
- **Zero lanes.** A lane that is 0 stays 0. No special casing is needed.

## Timing
- **Start edge T0.** Capture happens at edge T0, and `busy`=1 from T0. `mu_total` is valid from T0.
- **Mix steps.** The 24 mix steps occur on edges T1–T24.
- **Result.** `digest_valid` rises after T24: 24 cycles from capture to valid. The digest on that cycle is final.
- **Handshake.** Accepted at the first edge Tn ≥ T25 where `digest_ready`=1. `digest_valid` and `busy` are 0 after Tn. A new `start` is accepted from edge Tn+1 onward.
- **Back-pressure.** Holding `digest_ready` low keeps the unit in DONE indefinitely with the outputs stable.
- **Throughput.** At most one digest per 26 cycles.

## Test plan
- **All-zero snapshot.** `start` with every input 0 → after 24 cycles, `digest_valid`=1, `digest`=0 and `mu_total`=0.
- **Single μ.** `mu_discovery`=1, all other inputs 0 → lanes 2 and 3 are 0x00042021, other lanes are 0, `mu_total`=1. Valid exactly 24 cycles after capture.
- **Lane mapping.** `mask0`=0x1 and `mem1`=0x1, all else 0 → `digest[159:128]`=0x00042021 and `digest[255:224]`=0x00042021, other bits 0. Separately, `pc`=5 with `next_id`=5 → lane0 = 0.
- **Back-pressure and ignored start.** Hold `digest_ready`=0 for 10 cycles in DONE while pulsing `start` with new data → `digest` and `mu_total` stay unchanged and `digest_valid` stays high. Raising `ready` clears valid on the next edge.
- **Reset mid-MIX.** Assert `rst_n`=0 at T10 → the next cycle shows `busy`=0, `digest`=0 and `mu_total`=0. A fresh `start` then yields the correct digest.
- **Wrap.** `mu_discovery`=0xFFFF_FFFF_FFFF_FFFF with `mu_execution`=2 → `mu_total`=1 and lane3 = 0x00042021.
